// File: rtl/apb_audio_fifo.sv
// APB3 completer buffering 8-bit audio samples in a FIFO and replaying them as PWM,
// one sample per programmable period, with a level/underrun interrupt.
module apb_audio_fifo #(
    parameter int DEPTH = 64,
    parameter int LW    = 7
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PWM_OUT,
    output logic        IRQ
);

    localparam int AW = LW - 1;

    // APB handshake: PREADY is constantly 1, so every access phase (PSEL & PENABLE)
    // completes on the next rising edge; writes commit there, reads are purely combinational.
    logic [5:0] word;
    logic       apb_wr;
    logic       sel_ctrl, sel_status, sel_data, sel_rate, sel_thresh, addr_ok;

    logic          en, irq_en, underrun;
    logic [15:0]   rate, timer;
    logic [LW-1:0] thresh, level;
    logic [AW-1:0] wptr, rptr;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    sample, pwm_cnt;
    logic          pwm_out, irq;

    logic empty, full, push, pop, flush, tick, urun_set;
    logic unused_bits;

    assign word       = PADDR[7:2];
    assign apb_wr     = PSEL & PENABLE & PWRITE;
    assign sel_ctrl   = (word == 6'd0);
    assign sel_status = (word == 6'd1);
    assign sel_data   = (word == 6'd2);
    assign sel_rate   = (word == 6'd3);
    assign sel_thresh = (word == 6'd4);
    assign addr_ok    = sel_ctrl | sel_status | sel_data | sel_rate | sel_thresh;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // FULL is judged before the edge, so a same-cycle pop never rescues a push.
    assign push     = apb_wr & sel_data & ~full;
    assign flush    = apb_wr & sel_ctrl & PWDATA[1];
    assign tick     = en & (timer == 16'd0);
    assign pop      = tick & ~flush & ~empty;
    assign urun_set = tick & ~flush & empty;

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & PWRITE & (~addr_ok | (sel_data & full));
    assign PWM_OUT = pwm_out;
    assign IRQ     = irq;

    assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

    always_comb begin
        PRDATA = '0;
        if (PSEL & ~PWRITE) begin
            case (word)
                6'd0: begin
                    PRDATA[0] = en;
                    PRDATA[2] = irq_en;
                end
                6'd1: begin
                    PRDATA[LW-1:0] = level;
                    PRDATA[8]      = empty;
                    PRDATA[9]      = full;
                    PRDATA[10]     = underrun;
                end
                6'd3:    PRDATA[15:0]   = rate;
                6'd4:    PRDATA[LW-1:0] = thresh;
                default: PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wptr] <= PWDATA[7:0];
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            en       <= 1'b0;
            irq_en   <= 1'b0;
            rate     <= 16'h00FF;
            thresh   <= '0;
            underrun <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            sample   <= '0;
            timer    <= 16'h00FF;
            pwm_cnt  <= '0;
            pwm_out  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (apb_wr & sel_ctrl) begin
                en     <= PWDATA[0];
                irq_en <= PWDATA[2];
            end
            if (apb_wr & sel_rate)   rate   <= PWDATA[15:0];
            if (apb_wr & sel_thresh) thresh <= PWDATA[LW-1:0];

            if (urun_set)
                underrun <= 1'b1;
            else if (apb_wr & sel_status & PWDATA[10])
                underrun <= 1'b0;

            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop) begin
                    rptr   <= rptr + AW'(1);
                    sample <= mem[rptr];
                end
                level <= level + LW'(push) - LW'(pop);
            end

            // Held at RATE while disabled, so the first tick lands RATE+1 cycles after EN rises.
            if (!en || timer == 16'd0)
                timer <= rate;
            else
                timer <= timer - 16'd1;

            pwm_cnt <= en ? pwm_cnt + 8'd1 : 8'd0;
            pwm_out <= en & (pwm_cnt < sample);
            irq     <= irq_en & ((level <= thresh) | underrun);
        end
    end

endmodule

// File: tb/tb_apb_audio_fifo.sv
// Directed bench for apb_audio_fifo: APB driver tasks, register/timing/PWM checks
// and a sample-order scoreboard fed by an expected queue.
module tb_apb_audio_fifo;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_DATA   = 8'h08;
  localparam logic [7:0] A_RATE   = 8'h0C;
  localparam logic [7:0] A_THRESH = 8'h10;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, PWM_OUT, IRQ;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  apb_audio_fifo #(.DEPTH(64), .LW(7)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PWM_OUT(PWM_OUT), .IRQ(IRQ)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: setup on a falling edge, access on the next, commit on the following rise
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      if (PWM_OUT) c++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] st [0:20];
    logic        err;
    int          cnt, errs;
    logic [7:0]  v;

    // 1: reset values
    #23 PRESERN = 1'b1;
    check("reset_pwm", {31'b0, PWM_OUT}, 32'd0);
    check("reset_irq", {31'b0, IRQ}, 32'd0);
    check("reset_pready", {31'b0, PREADY}, 32'd1);
    apb_read(A_CTRL, rd);   check("reset_ctrl", rd, 32'h0);
    apb_read(A_STATUS, rd); check("reset_status", rd, 32'h100);
    apb_read(A_RATE, rd);   check("reset_rate", rd, 32'hFF);
    apb_read(A_THRESH, rd); check("reset_thresh", rd, 32'h0);
    apb_read(A_DATA, rd);   check("data_reads_zero", rd, 32'h0);

    // 2: pop timing and PWM duty
    wr(A_RATE, 32'd9);
    wr(A_DATA, 32'h40);
    wr(A_DATA, 32'h80);
    wr(A_CTRL, 32'h1);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = A_STATUS;
    for (int k = 0; k <= 20; k++) begin
      @(negedge PCLK);
      st[k] = PRDATA;
    end
    PSEL = 1'b0;
    check("lvl_before_pop1", st[9], 32'h002);
    check("lvl_after_pop1", st[10], 32'h001);
    check("lvl_before_pop2", st[19], 32'h001);
    check("lvl_after_pop2", st[20], 32'h100);
    repeat (10) @(negedge PCLK);
    count_high(256, cnt); check("pwm_duty_80", cnt, 32'd128);
    wr(A_DATA, 32'h40);
    repeat (25) @(negedge PCLK);
    count_high(256, cnt); check("pwm_duty_40", cnt, 32'd64);
    wr(A_DATA, 32'hFF);
    repeat (25) @(negedge PCLK);
    count_high(256, cnt); check("pwm_duty_ff", cnt, 32'd255);
    wr(A_DATA, 32'h00);
    repeat (25) @(negedge PCLK);
    count_high(256, cnt); check("pwm_duty_00", cnt, 32'd0);

    // 3: fill to FULL, overflow rejected, pop order preserved
    wr(A_CTRL, 32'h0);
    wr(A_CTRL, 32'h2);
    wr(A_STATUS, 32'h400);
    wr(A_RATE, 32'd255);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      v = 8'(i * 4 + 1);
      apb_write(A_DATA, {24'b0, v}, err);
      if (err) errs++;
      exp_q.push_back(v);
    end
    check("fill_no_slverr", errs, 32'd0);
    apb_read(A_STATUS, rd); check("status_full", rd, 32'h240);
    apb_write(A_DATA, 32'hAA, err);
    check("overflow_slverr", {31'b0, err}, 32'd1);
    apb_read(A_STATUS, rd); check("status_after_overflow", rd, 32'h240);
    wr(A_CTRL, 32'h1);
    repeat (257) @(negedge PCLK);
    for (int j = 0; j < 64; j++) begin
      count_high(256, cnt);
      check($sformatf("pop_order_%0d", j), cnt, {24'b0, exp_q.pop_front()});
    end

    // 4: underrun, sample hold, IRQ and W1C
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h400);
    wr(A_RATE, 32'd3);
    apb_read(A_STATUS, rd); check("urun_cleared", rd, 32'h100);
    wr(A_CTRL, 32'h1);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = A_STATUS;
    for (int k = 0; k <= 4; k++) begin
      @(negedge PCLK);
      st[k] = PRDATA;
    end
    PSEL = 1'b0;
    check("urun_before_tick", st[3], 32'h100);
    check("urun_at_tick", st[4], 32'h500);
    count_high(256, cnt); check("sample_holds", cnt, 32'd253);
    wr(A_CTRL, 32'h5);
    repeat (2) @(negedge PCLK);
    check("irq_on_urun", {31'b0, IRQ}, 32'd1);
    wr(A_CTRL, 32'h4);
    wr(A_DATA, 32'h11);
    wr(A_STATUS, 32'h400);
    repeat (2) @(negedge PCLK);
    check("irq_cleared", {31'b0, IRQ}, 32'd0);
    apb_read(A_STATUS, rd); check("status_one_entry", rd, 32'h001);
    wr(A_THRESH, 32'd1);
    repeat (2) @(negedge PCLK);
    check("irq_on_thresh", {31'b0, IRQ}, 32'd1);
    apb_read(A_THRESH, rd); check("thresh_rb", rd, 32'd1);

    // 5: flush on the tick edge
    wr(A_THRESH, 32'd0);
    wr(A_CTRL, 32'h2);
    wr(A_STATUS, 32'h400);
    wr(A_RATE, 32'd20);
    for (int i = 0; i < 5; i++) wr(A_DATA, 32'h10 + i);
    apb_read(A_STATUS, rd); check("five_entries", rd, 32'h005);
    wr(A_CTRL, 32'h1);
    repeat (19) @(posedge PCLK);
    #1 wr(A_CTRL, 32'h3);
    apb_read(A_STATUS, rd); check("flush_status", rd, 32'h100);
    apb_read(A_CTRL, rd);   check("flush_self_clear", rd, 32'h1);
    repeat (15) @(posedge PCLK);
    #1 wr(A_CTRL, 32'h3);
    apb_read(A_STATUS, rd); check("flush_beats_urun", rd, 32'h100);

    // 6: bad address, then asynchronous reset mid-stream
    apb_write(8'h14, 32'hFFFF, err);
    check("bad_addr_slverr", {31'b0, err}, 32'd1);
    apb_read(A_CTRL, rd);   check("bad_addr_ctrl", rd, 32'h1);
    apb_read(A_RATE, rd);   check("bad_addr_rate", rd, 32'd20);
    apb_read(A_THRESH, rd); check("bad_addr_thresh", rd, 32'd0);
    wr(A_CTRL, 32'h5);
    repeat (30) @(negedge PCLK);
    check("irq_before_reset", {31'b0, IRQ}, 32'd1);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = A_CTRL;
    #1 check("ctrl_peek_before_reset", PRDATA, 32'h5);
    @(posedge PCLK);
    #3 PRESERN = 1'b0;
    #1;
    check("rst_pwm", {31'b0, PWM_OUT}, 32'd0);
    check("rst_irq", {31'b0, IRQ}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    PSEL = 1'b0;
    #20;
    @(negedge PCLK) PRESERN = 1'b1;
    apb_read(A_STATUS, rd); check("post_rst_status", rd, 32'h100);
    apb_read(A_RATE, rd);   check("post_rst_rate", rd, 32'hFF);
    apb_read(A_CTRL, rd);   check("post_rst_ctrl", rd, 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_audio_fifo.md
Name: apb_audio_fifo

Overview:
APB3 completer (slave) on the fabric side of the MSS APB master port. It turns CPU-written 8-bit audio samples into a PWM stream on the SPEAKER_DAC path. The block buffers samples in a FIFO and releases one per programmable sample period. It raises an interrupt when the FIFO drains to a threshold.

Parameters:
DEPTH, 64, FIFO entries; power of 2, minimum 4.
LW, 7, level counter width, log2(DEPTH)+1.

Ports:
PCLK  in  1  fabric clock (FAB_CLK); all logic on the rising edge.
PRESERN  in  1  asynchronous active-low reset (M2F_RESET_N).
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write.
PADDR  in  8  byte address; bits [1:0] ignored.
PWDATA  in  32  write data.
PRDATA  out  32  read data.
PREADY  out  1  tied to 1; zero wait states.
PSLVERR  out  1  transfer error.
PWM_OUT  out  1  PWM audio output.
IRQ  out  1  level-sensitive interrupt.

Behaviour:
- Reset: all registers 0 and FIFO empty. PRDATA=0, PSLVERR=0, PWM_OUT=0, IRQ=0. RATE resets to 0x00FF.
- APB:
  - A write commits on the edge where PSEL&PENABLE&PWRITE=1.
  - PRDATA is combinational from PADDR when PSEL&!PWRITE; otherwise 0.
  - PSLVERR is combinational and asserts only when PSEL&PENABLE.
- Register map:
  - 0x00 CTRL RW:
    - bit0 EN.
    - bit1 FLUSH: write-only, self-clearing, reads 0.
    - bit2 IRQ_EN.
  - 0x04 STATUS:
    - [LW-1:0] LEVEL.
    - bit8 EMPTY, bit9 FULL.
    - bit10 UNDERRUN: sticky; writing 1 to bit10 clears it; all other bits are RO.
  - 0x08 DATA WO:
    - A write pushes PWDATA[7:0].
    - Write while FULL: data dropped, PSLVERR=1, LEVEL unchanged.
    - Read returns 0.
  - 0x0C RATE RW [15:0]: sample period = RATE+1 PCLK cycles.
  - 0x10 THRESH RW [LW-1:0].
  - Any other address: read 0; write ignored with PSLVERR=1.
- Sample timer:
  - While EN=0, the down-counter is held at RATE.
  - While EN=1, it decrements each cycle. At 0 it reloads RATE and generates a tick (one cycle).
  - First tick occurs RATE+1 cycles after EN rises.
- Tick handling:
  - If FIFO not empty: pop head into SAMPLE (visible next cycle).
  - If FIFO empty: SAMPLE holds and UNDERRUN is set.
- PWM:
  - 8-bit counter free-runs while EN=1; it is cleared and held at 0 while EN=0.
  - PWM_OUT is registered: PWM_OUT <= EN & (pwm_cnt < SAMPLE).
  - SAMPLE=0 gives a constant 0. SAMPLE=0xFF gives high 255 of 256 cycles.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo DEPTH.
  - Push and pop in the same cycle: both occur, LEVEL unchanged.
  - Push to a full FIFO when a pop occurs in the same cycle is still rejected. FULL is sampled before the edge; PSLVERR=1.
- FLUSH:
  - Pointers and LEVEL are set to 0 on the commit edge.
  - A tick coinciding with FLUSH: flush wins, no pop, UNDERRUN not set.
  - SAMPLE retained.
- IRQ is registered: IRQ <= IRQ_EN & (LEVEL <= THRESH | UNDERRUN).
- UNDERRUN set and W1C on the same edge: set wins.
- RATE written mid-period: takes effect at the next reload.
- EN cleared mid-period: the counter reloads. The FIFO and SAMPLE are untouched.
- PRESERN asserted at any time returns every register, pointer and output to its reset value asynchronously. No partial transfer completes.

Test Plan:
1. Reset then read every register → CTRL=0, STATUS=0x100 (EMPTY), RATE=0xFF, THRESH=0; PWM_OUT=0, IRQ=0, PREADY=1 throughout.
2. Push 0x40,0x80; RATE=9; EN=1 → first pop 10 cycles after EN, second 20 cycles after EN; PWM_OUT high 64 of 256 cycles while SAMPLE=0x40; LEVEL reads 2→1→0.
3. Push 64 bytes, then a 65th → STATUS FULL=1, LEVEL=64, PSLVERR=1 on the 65th access only, FIFO contents unchanged (pop order 0..63).
4. FIFO empty, EN=1, RATE=3 → UNDERRUN=1 after 4 cycles, SAMPLE holds; IRQ_EN=1 gives IRQ=1; writing 0x400 to STATUS clears UNDERRUN and IRQ (THRESH<LEVEL after a push).
5. FIFO holds 5 entries, CTRL write FLUSH=1 on the same edge as a tick → LEVEL=0, EMPTY=1, UNDERRUN=0, CTRL reads bit1=0.
6. Write to 0x14 → PSLVERR=1, no register changes; assert PRESERN low mid-stream → all outputs 0 immediately, STATUS=0x100 after release.
